// File: rtl/alu_result_reader.sv
// Streams CPU ALU result words to a host one byte at a time, LSB first, over a four-phase ack handshake.
// Define RESULT_CHKSUM_EN to append an XOR-of-data-bytes checksum byte after each word.
module alu_result_reader #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 res_valid,
    input  logic [DATAWIDTH-1:0] res_data,
    input  logic                 byte_ack,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    output logic                 busy,
    output logic                 overflow
);
    localparam int NBYTES = DATAWIDTH / 8;
`ifdef RESULT_CHKSUM_EN
    localparam int LAST_IDX = NBYTES;
`else
    localparam int LAST_IDX = NBYTES - 1;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [DATAWIDTH-1:0] hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [3:0]           idx_q, idx_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           byte_out_q, byte_out_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 busy_q, busy_d;
    logic                 take_s, drop_s;

`ifdef RESULT_CHKSUM_EN
    logic [7:0] chk_q, chk_d;

    function automatic logic [7:0] xor_bytes(input logic [DATAWIDTH-1:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            acc = acc ^ w[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // A strobe goes to the holding register unless IDLE consumes it directly; in IDLE a
    // pending word moves to the shifter in the same cycle, so the holding slot is free again.
    assign take_s = res_valid && (hold_vld_q ? (state_q == IDLE) : (state_q != IDLE));
    assign drop_s = res_valid && hold_vld_q && (state_q != IDLE);

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = take_s ? res_data : hold_q;
        hold_vld_d = hold_vld_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | drop_s;
`ifdef RESULT_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    shift_d    = hold_q;
                    hold_vld_d = 1'b0;
                    idx_d      = 4'd0;
                    state_d    = PRESENT;
`ifdef RESULT_CHKSUM_EN
                    chk_d      = xor_bytes(hold_q);
`endif
                end else if (res_valid) begin
                    shift_d    = res_data;
                    idx_d      = 4'd0;
                    state_d    = PRESENT;
`ifdef RESULT_CHKSUM_EN
                    chk_d      = xor_bytes(res_data);
`endif
                end else begin
                    state_d    = IDLE;
                end
            end
            PRESENT: begin
                if (byte_ack) begin
                    state_d = WAIT_REL;
                end else begin
                    state_d = PRESENT;
                end
            end
            WAIT_REL: begin
                if (!byte_ack) begin
                    if (idx_q == 4'(LAST_IDX)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = PRESENT;
`ifdef RESULT_CHKSUM_EN
                        if (idx_q == 4'(NBYTES - 1)) begin
                            shift_d = {{(DATAWIDTH-8){1'b0}}, chk_q};
                        end else begin
                            shift_d = shift_q >> 8;
                        end
`else
                        shift_d = shift_q >> 8;
`endif
                    end
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hold_vld_d   = hold_vld_d | take_s;
        byte_valid_d = (state_d == PRESENT);
        byte_out_d   = (state_d == PRESENT) ? shift_d[7:0] : 8'h00;
        busy_d       = (state_d != IDLE) | hold_vld_d;
    end

    // State, storage and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            idx_q        <= 4'd0;
            overflow_q   <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RESULT_CHKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
`ifdef RESULT_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/alu_result_reader.md
ALU_RESULT_READER -- requirements
Module: alu_result_reader

Interface
REQ-001 Parameter DATAWIDTH, default 32, result word width; SHALL be a multiple of 8, 8..64.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 res_valid  input  1  one-cycle strobe: res_data holds a new CPU result.
REQ-005 res_data  input  DATAWIDTH  CPU ALU result word.
REQ-006 byte_ack  input  1  host acknowledge, four-phase level handshake.
REQ-007 byte_out  output  8  current byte presented to host.
REQ-008 byte_valid  output  1  byte_out valid; held until acknowledged.
REQ-009 busy  output  1  high while a word is being streamed or is pending.
REQ-010 overflow  output  1  sticky: a result was dropped because both buffers were full.

Function
REQ-011 Storage SHALL be one shift register (active word) plus one holding register (pending word, with a valid bit).
REQ-012 FSM states SHALL be IDLE, PRESENT, WAIT_REL.
REQ-013 IDLE: if holding valid, load it into shift register, clear holding valid, go PRESENT; else if res_valid, load res_data directly, go PRESENT.
REQ-014 PRESENT: byte_valid=1, byte_out = shift[7:0]; on byte_ack=1 go WAIT_REL next cycle with byte_valid=0.
REQ-015 WAIT_REL: byte_valid=0; on byte_ack=0, shift right 8 and go PRESENT if bytes remain, else go IDLE.
REQ-016 Byte order SHALL be least-significant byte first; DATAWIDTH/8 bytes per word.
REQ-017 byte_out SHALL be stable whenever byte_valid=1; byte_out=0 in IDLE.
REQ-018 Latency: res_valid in IDLE at cycle N -> byte_valid=1 at cycle N+1.
REQ-019 res_valid while not IDLE: captured into holding if empty; if holding full, word dropped and overflow set.
REQ-020 res_valid in the same cycle WAIT_REL completes the last byte: captured into holding; next word starts from IDLE on the following cycle, no loss.
REQ-021 byte_ack high in IDLE, or already high on entry to PRESENT from IDLE, SHALL be treated per REQ-014 (no special gating); host is responsible for releasing ack.
REQ-022 busy = (state != IDLE) OR holding valid.
REQ-023 overflow SHALL clear only on rst.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, shift and holding registers=0, holding valid=0, byte_valid=0, byte_out=0, busy=0, overflow=0.
REQ-025 rst mid-transfer SHALL abort the word with no further bytes presented; res_valid during rst is ignored.

Configuration
REQ-026 Macro RESULT_CHKSUM_EN: when defined, after the last data byte one extra byte SHALL be presented, equal to the XOR of all data bytes of that word, using the same handshake; busy covers it.
REQ-027 Without RESULT_CHKSUM_EN: exactly DATAWIDTH/8 bytes per word; no checksum logic present.

Verification
REQ-028 Reset then res_data=0x12345678 strobe, host acks each byte -> bytes 0x78,0x56,0x34,0x12, busy drops after last ack release.
REQ-029 Host holds ack low 20 cycles in PRESENT -> byte_valid=1 and byte_out=0x78 constant for all 20 cycles.
REQ-030 Word A=0xAABBCCDD streaming, B=0x01020304 strobed, C=0xFFFFFFFF strobed -> A then B output complete; C dropped; overflow=1.
REQ-031 B strobed in the exact cycle A's final ack release is seen -> B streamed in full, overflow=0.
REQ-032 rst asserted after second byte of 0xDEADBEEF -> byte_valid=0, busy=0 next cycle; no further bytes until a new strobe.
REQ-033 RESULT_CHKSUM_EN defined, res_data=0x12345678 -> 0x78,0x56,0x34,0x12,0x08; undefined -> only the first four bytes.
